// File: rtl/csr_file_if.sv
// Request/response bundle between the CSR unit (initiator) and the CSR file (responder).
// Reads are answered combinationally; writes land on the next clock edge.
interface csr_file_if #(
    parameter int XLEN = 64
);
    logic            rd_valid;
    logic [11:0]     rd_csr;
    logic [XLEN-1:0] rd_data;
    logic            wr_valid;
    logic [11:0]     wr_csr;
    logic [XLEN-1:0] wr_data;

    modport master (
        output rd_valid, rd_csr, wr_valid, wr_csr, wr_data,
        input  rd_data
    );

    modport slave (
        input  rd_valid, rd_csr, wr_valid, wr_csr, wr_data,
        output rd_data
    );
endinterface

// File: rtl/csr_file.sv
// Architectural M-mode CSR file: zero-latency reads, registered writes, cycle/instret counters,
// and trap/mret updates from commit. It also exports the mret target, trap vector and interrupt-pending state.
module csr_file #(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] HART_ID  = {XLEN{1'b0}},
    parameter logic [XLEN-1:0] MISA_VAL = 64'h8000_0000_0014_1129,
    parameter int              GRAD_W   = 2
) (
    input  logic              clock,
    input  logic              reset,
    csr_file_if.slave         csr_port,
    input  logic [GRAD_W-1:0] instret_inc,
    input  logic              trap_valid,
    input  logic [XLEN-1:0]   trap_cause,
    input  logic [XLEN-1:0]   trap_epc,
    input  logic [XLEN-1:0]   trap_tval,
    input  logic              mret_valid,
    input  logic [2:0]        irq_lines,
    output logic [XLEN-1:0]   mepc_out,
    output logic [XLEN-1:0]   trap_target_out,
    output logic              irq_pending_out,
    output logic [2:0]        frm_out
);

    localparam logic [11:0] CSR_NONE     = 12'h000;
    localparam logic [11:0] CSR_FFLAGS   = 12'h001;
    localparam logic [11:0] CSR_FRM      = 12'h002;
    localparam logic [11:0] CSR_FCSR     = 12'h003;
    localparam logic [11:0] CSR_MSTATUS  = 12'h300;
    localparam logic [11:0] CSR_MISA     = 12'h301;
    localparam logic [11:0] CSR_MIE      = 12'h304;
    localparam logic [11:0] CSR_MTVEC    = 12'h305;
    localparam logic [11:0] CSR_MSCRATCH = 12'h340;
    localparam logic [11:0] CSR_MEPC     = 12'h341;
    localparam logic [11:0] CSR_MCAUSE   = 12'h342;
    localparam logic [11:0] CSR_MTVAL    = 12'h343;
    localparam logic [11:0] CSR_MIP      = 12'h344;
    localparam logic [11:0] CSR_MCYCLE   = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET = 12'hB02;
    localparam logic [11:0] CSR_CYCLE    = 12'hC00;
    localparam logic [11:0] CSR_INSTRET  = 12'hC02;
    localparam logic [11:0] CSR_MHARTID  = 12'hF14;

    localparam logic [XLEN-1:0] XLEN_ZERO = {XLEN{1'b0}};
    localparam logic [XLEN-1:0] XLEN_ONE  = {{(XLEN-1){1'b0}}, 1'b1};

    // MPP is hardwired to machine mode; only MIE and MPIE are stored.
    function automatic logic [XLEN-1:0] mstatus_view(input logic mpie, input logic mie);
        logic [XLEN-1:0] v;
        v        = XLEN_ZERO;
        v[12:11] = 2'b11;
        v[7]     = mpie;
        v[3]     = mie;
        return v;
    endfunction

    // Places a {MEI, MTI, MSI} triple at bits 11/7/3, shared by mie and mip.
    function automatic logic [XLEN-1:0] irq_view(input logic [2:0] bits);
        logic [XLEN-1:0] v;
        v     = XLEN_ZERO;
        v[11] = bits[2];
        v[7]  = bits[1];
        v[3]  = bits[0];
        return v;
    endfunction

    // Reserved MODE encodings 2/3 keep the current MODE; BASE always follows the write.
    function automatic logic [XLEN-1:0] mtvec_warl(input logic [XLEN-1:0] cur, input logic [XLEN-1:0] wdata);
        logic [1:0] mode;
        mode = wdata[1] ? cur[1:0] : wdata[1:0];
        return {wdata[XLEN-1:2], mode};
    endfunction

    function automatic logic [XLEN-1:0] trap_vector(input logic [XLEN-1:0] tvec, input logic [XLEN-1:0] cause);
        logic [XLEN-1:0] base;
        base = {tvec[XLEN-1:2], 2'b00};
        if ((tvec[1:0] == 2'b01) && cause[XLEN-1]) begin
            return base + {cause[XLEN-3:0], 2'b00};
        end else begin
            return base;
        end
    endfunction

    logic [4:0]      fflags_r,     fflags_nx_s;
    logic [2:0]      frm_r,        frm_nx_s;
    logic            mstat_mie_r,  mstat_mie_nx_s;
    logic            mstat_mpie_r, mstat_mpie_nx_s;
    logic [2:0]      mie_en_r,     mie_en_nx_s;
    logic [XLEN-1:0] mtvec_r,      mtvec_nx_s;
    logic [XLEN-1:0] mscratch_r,   mscratch_nx_s;
    logic [XLEN-1:0] mepc_r,       mepc_nx_s;
    logic [XLEN-1:0] mcause_r,     mcause_nx_s;
    logic [XLEN-1:0] mtval_r,      mtval_nx_s;
    logic [XLEN-1:0] mcycle_r,     mcycle_nx_s;
    logic [XLEN-1:0] minstret_r,   minstret_nx_s;
    logic [11:0]     rd_sel_s;
    logic [11:0]     wr_sel_s;
    logic [XLEN-1:0] rd_data_s;

    // An invalid request is steered to an unimplemented address so it decodes to nothing.
    assign rd_sel_s = csr_port.rd_valid ? csr_port.rd_csr : CSR_NONE;
    assign wr_sel_s = csr_port.wr_valid ? csr_port.wr_csr : CSR_NONE;

    // Read mux over current state; same-cycle writes are not forwarded.
    always_comb begin
        rd_data_s = XLEN_ZERO;
        case (rd_sel_s)
            CSR_FFLAGS:                rd_data_s = {{(XLEN-5){1'b0}}, fflags_r};
            CSR_FRM:                   rd_data_s = {{(XLEN-3){1'b0}}, frm_r};
            CSR_FCSR:                  rd_data_s = {{(XLEN-8){1'b0}}, frm_r, fflags_r};
            CSR_MSTATUS:               rd_data_s = mstatus_view(mstat_mpie_r, mstat_mie_r);
            CSR_MISA:                  rd_data_s = MISA_VAL;
            CSR_MIE:                   rd_data_s = irq_view(mie_en_r);
            CSR_MTVEC:                 rd_data_s = mtvec_r;
            CSR_MSCRATCH:              rd_data_s = mscratch_r;
            CSR_MEPC:                  rd_data_s = mepc_r;
            CSR_MCAUSE:                rd_data_s = mcause_r;
            CSR_MTVAL:                 rd_data_s = mtval_r;
            CSR_MIP:                   rd_data_s = irq_view(irq_lines);
            CSR_MCYCLE, CSR_CYCLE:     rd_data_s = mcycle_r;
            CSR_MINSTRET, CSR_INSTRET: rd_data_s = minstret_r;
            CSR_MHARTID:               rd_data_s = HART_ID;
            default:                   rd_data_s = XLEN_ZERO;
        endcase
    end

    assign csr_port.rd_data = rd_data_s;

    // Next-state: counters tick, CSR writes apply, then trap/mret override the fields they own.
    always_comb begin
        fflags_nx_s     = fflags_r;
        frm_nx_s        = frm_r;
        mstat_mie_nx_s  = mstat_mie_r;
        mstat_mpie_nx_s = mstat_mpie_r;
        mie_en_nx_s     = mie_en_r;
        mtvec_nx_s      = mtvec_r;
        mscratch_nx_s   = mscratch_r;
        mepc_nx_s       = mepc_r;
        mcause_nx_s     = mcause_r;
        mtval_nx_s      = mtval_r;
        mcycle_nx_s     = mcycle_r + XLEN_ONE;
        minstret_nx_s   = minstret_r + {{(XLEN-GRAD_W){1'b0}}, instret_inc};

        case (wr_sel_s)
            CSR_FFLAGS:   fflags_nx_s = csr_port.wr_data[4:0];
            CSR_FRM:      frm_nx_s    = csr_port.wr_data[2:0];
            CSR_FCSR: begin
                frm_nx_s    = csr_port.wr_data[7:5];
                fflags_nx_s = csr_port.wr_data[4:0];
            end
            CSR_MSTATUS: begin
                mstat_mie_nx_s  = csr_port.wr_data[3];
                mstat_mpie_nx_s = csr_port.wr_data[7];
            end
            CSR_MIE:      mie_en_nx_s   = {csr_port.wr_data[11], csr_port.wr_data[7], csr_port.wr_data[3]};
            CSR_MTVEC:    mtvec_nx_s    = mtvec_warl(mtvec_r, csr_port.wr_data);
            CSR_MSCRATCH: mscratch_nx_s = csr_port.wr_data;
            CSR_MEPC:     mepc_nx_s     = {csr_port.wr_data[XLEN-1:1], 1'b0};
            CSR_MCAUSE:   mcause_nx_s   = csr_port.wr_data;
            CSR_MTVAL:    mtval_nx_s    = csr_port.wr_data;
            CSR_MCYCLE:   mcycle_nx_s   = csr_port.wr_data;
            CSR_MINSTRET: minstret_nx_s = csr_port.wr_data;
            default:      mscratch_nx_s = mscratch_r;
        endcase

        case ({trap_valid, mret_valid})
            2'b10, 2'b11: begin
                mepc_nx_s       = {trap_epc[XLEN-1:1], 1'b0};
                mcause_nx_s     = trap_cause;
                mtval_nx_s      = trap_tval;
                mstat_mpie_nx_s = mstat_mie_r;
                mstat_mie_nx_s  = 1'b0;
            end
            2'b01: begin
                mstat_mie_nx_s  = mstat_mpie_r;
                mstat_mpie_nx_s = 1'b1;
            end
            default: mepc_nx_s = mepc_nx_s;
        endcase
    end

    // Architectural state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fflags_r     <= 5'd0;
            frm_r        <= 3'd0;
            mstat_mie_r  <= 1'b0;
            mstat_mpie_r <= 1'b0;
            mie_en_r     <= 3'd0;
            mtvec_r      <= XLEN_ZERO;
            mscratch_r   <= XLEN_ZERO;
            mepc_r       <= XLEN_ZERO;
            mcause_r     <= XLEN_ZERO;
            mtval_r      <= XLEN_ZERO;
            mcycle_r     <= XLEN_ZERO;
            minstret_r   <= XLEN_ZERO;
        end else begin
            fflags_r     <= fflags_nx_s;
            frm_r        <= frm_nx_s;
            mstat_mie_r  <= mstat_mie_nx_s;
            mstat_mpie_r <= mstat_mpie_nx_s;
            mie_en_r     <= mie_en_nx_s;
            mtvec_r      <= mtvec_nx_s;
            mscratch_r   <= mscratch_nx_s;
            mepc_r       <= mepc_nx_s;
            mcause_r     <= mcause_nx_s;
            mtval_r      <= mtval_nx_s;
            mcycle_r     <= mcycle_nx_s;
            minstret_r   <= minstret_nx_s;
        end
    end

    assign mepc_out        = mepc_r;
    assign frm_out         = frm_r;
    assign trap_target_out = trap_vector(mtvec_r, trap_cause);
    assign irq_pending_out = (|(mie_en_r & irq_lines)) & mstat_mie_r;

endmodule
